// File: rtl/seq_divider_4bit_pkg.sv
// Shared definitions for the sequential 4-bit restoring divider:
// the controller state encoding, the operand width and the quotient
// reported when the divisor is zero.
package seq_divider_4bit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } div_state_t;

    localparam int DIV_WIDTH = 4;

    localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT = 4'hF;

endpackage : seq_divider_4bit_pkg

// File: rtl/seq_divider_4bit_sub.sv
// Existing combinational 4-bit subtractor: diff = a - b, with
// borrow_out set whenever b is larger than a (unsigned).
module subtractor_4bit
    import seq_divider_4bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] w_wide;

    // One extra bit on the left catches the borrow out of the top position
    always_comb begin
        w_wide     = {1'b0, a} - {1'b0, b};
        diff       = w_wide[WIDTH-1:0];
        borrow_out = w_wide[WIDTH];
    end

endmodule : subtractor_4bit

// File: rtl/seq_divider_4bit.sv
// Sequential restoring divider for unsigned operands. One trial
// subtraction per clock on a single shared subtractor, so a division
// takes WIDTH cycles from the accepting edge to the done pulse. A zero
// divisor is answered immediately on the accepting edge.
module seq_divider_4bit
    import seq_divider_4bit_pkg::*;
#(
    parameter int               WIDTH   = DIV_WIDTH,
    parameter logic [WIDTH-1:0] DZ_QUOT = DIV_DZ_QUOT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_subA;
    logic [WIDTH-1:0] w_subB;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_newR;
    logic [WIDTH-1:0] w_newQ;

    // Partial remainder shifted left with the next dividend bit brought in;
    // the remainder stays below 2^k after k steps, so nothing falls off the top
    assign w_shifted = (r_r << 1) | WIDTH'(r_q[WIDTH-1]);

    // The subtractor only matters during CALC; hold its inputs at zero otherwise
    assign w_subA = (r_state == CALC) ? w_shifted : '0;
    assign w_subB = (r_state == CALC) ? r_d       : '0;

    subtractor_4bit #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a          (w_subA),
        .b          (w_subB),
        .diff       (w_diff),
        .borrow_out (w_borrow)
    );

    // Restoring step: keep the difference only when it did not borrow
    assign w_newR = w_borrow ? w_shifted : w_diff;
    assign w_newQ = {r_q[WIDTH-2:0], ~w_borrow};

    // Controller, datapath registers and registered outputs in one block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= '0;
                        r_cnt <= CNT_W'(WIDTH - 1);
                        if (divisor != '0) begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                        end else begin
                            r_quot <= DZ_QUOT;
                            r_rem  <= dividend;
                            r_dz   <= 1'b1;
                            r_done <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_r <= w_newR;
                    r_q <= w_newQ;
                    if (r_cnt == '0) begin
                        r_quot  <= w_newQ;
                        r_rem   <= w_newR;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

endmodule : seq_divider_4bit

// File: tb/tb_seq_divider_4bit.sv
// Self-checking bench for seq_divider_4bit: a hand-written vector table,
// an exhaustive plus randomized sweep against an arithmetic reference,
// and hand-written sequences for back-to-back, ignored start, chained
// divide-by-zero and mid-division reset.
module tb_seq_divider_4bit;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int testsRun;
    int testsFailed;
    int edgeCount;

    int         obsLat;
    int         obsBusyCnt;
    logic       obsBusyAtDone;
    logic [3:0] obsQ;
    logic [3:0] obsR;
    logic       obsDz;

    vec_t vecs[10];

    seq_divider_4bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Running count of rising edges, used to measure pulse spacing
    initial edgeCount = 0;
    always @(posedge clk) edgeCount++;

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain unsigned division, with the fixed zero-divisor answer
    function automatic vec_t refModel(input logic [3:0] a, input logic [3:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        if (b == 0) begin
            v.q  = 4'hF;
            v.r  = a;
            v.dz = 1'b1;
        end else begin
            v.q  = 4'(int'(a) / int'(b));
            v.r  = 4'(int'(a) % int'(b));
            v.dz = 1'b0;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Start one division and wait for its done pulse, recording what was seen
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        obsLat     = 0;
        obsBusyCnt = 0;
        while (!done && obsLat <= 20) begin
            if (busy) obsBusyCnt++;
            @(posedge clk);
            #1;
            obsLat++;
        end
        if (!done) obsLat = -1;
        obsBusyAtDone = busy;
        obsQ          = quotient;
        obsR          = remainder;
        obsDz         = div_by_zero;
    endtask

    // Compare one completed division with its expected record, then check
    // that done drops and the results hold on the following cycle
    task automatic checkResult(input vec_t v);
        string tag;
        int    expLat;
        tag    = $sformatf("%0d/%0d", v.a, v.b);
        expLat = v.dz ? 0 : 4;
        checkOutput({"quotient ", tag}, obsQ, v.q);
        checkOutput({"remainder ", tag}, obsR, v.r);
        checkOutput({"div_by_zero ", tag}, obsDz, v.dz);
        checkOutput({"latency ", tag}, obsLat, expLat);
        checkOutput({"busy cycles ", tag}, obsBusyCnt, expLat);
        checkOutput({"busy at done ", tag}, obsBusyAtDone, 0);
        @(posedge clk);
        #1;
        checkOutput({"done drop ", tag}, done, 0);
        checkOutput({"quotient hold ", tag}, quotient, v.q);
        checkOutput({"remainder hold ", tag}, remainder, v.r);
    endtask

    initial begin
        int   e0;
        int   pulses;
        int   lat;
        vec_t v;

        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        dividend    = 4'd0;
        divisor     = 4'd0;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
        vecs[1] = '{4'd7,  4'd9,  4'd0,  4'd7,  1'b0};
        vecs[2] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0};
        vecs[3] = '{4'd9,  4'd0,  4'hF,  4'd9,  1'b1};
        vecs[4] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
        vecs[5] = '{4'd12, 4'd5,  4'd2,  4'd2,  1'b0};
        vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
        vecs[7] = '{4'd0,  4'd0,  4'hF,  4'd0,  1'b1};
        vecs[8] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0};
        vecs[9] = '{4'd14, 4'd4,  4'd3,  4'd2,  1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset quotient", quotient, 0);
        checkOutput("reset remainder", remainder, 0);
        checkOutput("reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-written vector table
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            checkResult(vecs[i]);
        end

        // Back-to-back: 7/9, then 0/5 raised during the done cycle
        applyStimulus(4'd7, 4'd9);
        checkOutput("b2b first quotient", obsQ, 0);
        checkOutput("b2b first remainder", obsR, 7);
        e0       = edgeCount;
        start    = 1'b1;
        dividend = 4'd0;
        divisor  = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat <= 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("b2b done spacing", edgeCount - e0, 5);
        checkOutput("b2b second quotient", quotient, 0);
        checkOutput("b2b second remainder", remainder, 0);
        @(posedge clk);
        #1;

        // Start held with new operands during busy is ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd1;
        @(posedge clk);
        #1;
        dividend = 4'd6;
        divisor  = 4'd2;
        lat      = 0;
        while (!done && lat <= 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        checkOutput("held start latency", lat, 4);
        checkOutput("held start quotient", quotient, 15);
        checkOutput("held start remainder", remainder, 0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("held start extra done", pulses, 0);
        checkOutput("held start quotient kept", quotient, 15);

        // Chained divide-by-zero keeps done high on consecutive edges
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd0;
        @(posedge clk);
        #1;
        checkOutput("dz chain first done", done, 1);
        checkOutput("dz chain first remainder", remainder, 9);
        dividend = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("dz chain second done", done, 1);
        checkOutput("dz chain second remainder", remainder, 3);
        checkOutput("dz chain busy", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("dz chain done drop", done, 0);

        // Load a nonzero result so the mid-division reset is visible
        applyStimulus(4'd15, 4'd1);
        checkResult(refModel(4'd15, 4'd1));

        // Reset during iteration 2 aborts the division without done
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort quotient", quotient, 0);
        checkOutput("abort remainder", remainder, 0);
        checkOutput("abort div_by_zero", div_by_zero, 0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("abort no done", pulses, 0);
        applyStimulus(4'd12, 4'd5);
        checkResult(refModel(4'd12, 4'd5));

        // Exhaustive sweep over every operand pair
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                v = refModel(4'(a), 4'(b));
                applyStimulus(v.a, v.b);
                checkResult(v);
            end
        end

        // Randomized operand pairs
        for (int i = 0; i < 40; i++) begin
            v = refModel(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
            applyStimulus(v.a, v.b);
            checkResult(v);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_seq_divider_4bit

// File: doc/seq_divider_4bit.md
Name: seq_divider_4bit

Overview:
- Sequential restoring divider for unsigned 4-bit operands.
- Sequences a single subtractor_4bit instance over one iteration per clock, so each division performs WIDTH trial subtractions on the shared subtractor.
- Uses a start/busy/done handshake and sits next to the combinational arithmetic blocks as their first clocked consumer.

Parameters:
- WIDTH, 4, operand/result width. Must equal the subtractor width; only 4 is supported.
- DZ_QUOT, 4'hF, quotient returned on divide-by-zero.

Ports:
- clk  input  1  clock. Single clock domain, rising edge.
- rst_n  input  1  reset. Synchronous, active-low.
- start  input  1  request a division. Sampled only when busy=0.
- dividend  input  WIDTH  numerator. Captured on the accepting edge.
- divisor  input  WIDTH  denominator. Captured on the accepting edge.
- busy  output  1  division in progress. start is ignored while high.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  result, held until the next done.
- remainder  output  WIDTH  result, held until the next done.
- div_by_zero  output  1  set with done when divisor==0, held with results.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all outputs go to 0, state goes to IDLE, and internal registers clear. This applies mid-division too: the operation is aborted and no done pulse follows.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, iteration counter cnt runs from WIDTH-1 down to 0.
- Accept: at edge N, with state IDLE and start=1:
  - Latch Q_reg=dividend, D_reg=divisor, R_reg=0, cnt=WIDTH-1.
  - If divisor!=0: go to CALC, busy=1 from edge N.
  - If divisor==0: stay IDLE. At edge N set quotient=DZ_QUOT, remainder=dividend, div_by_zero=1, done=1 (1-cycle latency).
- CALC iteration at each edge N+1 to N+WIDTH:
  - shifted = {R_reg[WIDTH-2:0], Q_reg[WIDTH-1]}.
  - Drive subtractor a=shifted, b=D_reg.
  - If borrow_out=0: R_reg=diff and the new quotient bit is 1. Otherwise R_reg=shifted and the bit is 0.
  - Q_reg shifts left, taking the new quotient bit at the LSB.
  - Invariant: R after k iterations < 2^k, so shifted never exceeds WIDTH bits. No 5th bit is needed.
- Completion, at edge N+WIDTH (cnt==0):
  - quotient and remainder take their final values; div_by_zero=0; done=1 for exactly one cycle; busy=0; state returns to IDLE.
  - Latency from accepting edge to done edge is WIDTH cycles (4).
- done deasserts at the next edge unless a new divide-by-zero completes on that edge.
- Back-to-back: start=1 in the cycle done is high is accepted at the following edge (IDLE). There is no dead cycle beyond that.
- start while busy: ignored, not queued. Operand changes while busy have no effect.
- When start=0 in IDLE, all outputs hold.
- Subtractor inputs are don't-care outside CALC; tie them to 0 for a quiet waveform.

Decomposition:
- Shared package:
  - state encoding (IDLE=1'b0, CALC=1'b1),
  - WIDTH default,
  - DZ_QUOT constant.
- One sub-module: the existing subtractor_4bit, instantiated once. All control, shift registers and counter stay in seq_divider_4bit.

Test Plan:
- 13/3: start for one cycle → busy high for 4 cycles, then done pulses once with quotient=4, remainder=1, div_by_zero=0.
- 7/9 and 0/5 back-to-back (second start raised during the done cycle) → results q=0,r=7 then q=0,r=0; two done pulses 5 cycles apart.
- 9/0 → done on the edge after start, quotient=4'hF, remainder=9, div_by_zero=1, busy never asserted.
- 15/1 started, then start held with 6/2 during busy → only q=15,r=0 is reported; one done pulse; 6/2 is ignored.
- 12/5 started, rst_n=0 for one cycle at iteration 2 → all outputs 0, no done. A new 12/5 afterwards gives q=2,r=2.
- Exhaustive sweep over all 256 operand pairs against a reference model: q=a/b and r=a%b for b!=0; DZ values for b=0; latency checked every time.
